// File: rtl/fifo.sv
// fifo -- store-and-forward receive FIFO in front of the ACL datapath.
//   Frame words are written from an AXI-Stream style source and become readable
//   only after the frame's tlast word is accepted; i_fifo_invalid rewinds the
//   write side to the start of the uncommitted frame.
// Latency: default build has a one-cycle registered read (request -> o_data).
//   With FIFO_FWFT_EN defined the head word is presented combinationally
//   (first-word-fall-through) and i_rd_valid pops it.
// Backpressure: o_rxd_tready = !full, where full is wr_ptr+1 == rd_ptr
//   (511 usable words). It is derived from registered pointers only.
//   An oversize uncommitted frame holds tready low until it is dropped or reset.
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   i_rxd_tvalid        write word valid (accepted when o_rxd_tready=1)
//   i_rx_data           write data word
//   i_rx_tlast          last word of frame; commits the frame when written
//   i_fifo_invalid      drop the uncommitted frame; wins over a same-cycle write
//   i_rd_valid          pop request; ignored when nothing committed is available
//   o_data              read data (registered, or head word under FIFO_FWFT_EN)
//   o_wr_cnt            words held in the current uncommitted frame
//   o_rxd_tready        FIFO can accept a word
//
// Optional feature macro: FIFO_FWFT_EN (first-word-fall-through read port).

module fifo #(
  parameter int C_s_axis_rxd_TDATA_WIDTH = 32,
  parameter int fifo_depth               = 9
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_rxd_tvalid,
  input  logic                                i_rd_valid,
  input  logic                                i_rx_tlast,
  input  logic                                i_fifo_invalid,
  input  logic [C_s_axis_rxd_TDATA_WIDTH-1:0] i_rx_data,
  output logic [C_s_axis_rxd_TDATA_WIDTH-1:0] o_data,
  output logic [fifo_depth-1:0]               o_wr_cnt,
  output logic                                o_rxd_tready
);

  localparam int DW    = C_s_axis_rxd_TDATA_WIDTH;
  localparam int DEPTH = 1 << fifo_depth;
  localparam logic [fifo_depth-1:0] PTR_ONE = {{(fifo_depth-1){1'b0}}, 1'b1};

  // Storage: not reset, contents beyond the pointers are don't-care.
  logic [DW-1:0] mem_q [DEPTH];

  // wr_ptr: next write slot; commit_ptr: start of the uncommitted frame;
  // rd_ptr: next word to read. All wrap modulo DEPTH.
  logic [fifo_depth-1:0] wr_ptr_q, wr_ptr_d;
  logic [fifo_depth-1:0] commit_ptr_q, commit_ptr_d;
  logic [fifo_depth-1:0] rd_ptr_q, rd_ptr_d;

  logic [fifo_depth-1:0] wr_ptr_inc;
  logic                  full;
  logic                  wr_en;
  logic                  avail;
  logic                  rd_en;

  assign wr_ptr_inc   = wr_ptr_q + PTR_ONE;
  // One slot is sacrificed so that full and empty are distinguishable.
  assign full         = (wr_ptr_inc == rd_ptr_q);
  assign o_rxd_tready = ~full;

  // A drop in the same cycle discards the incoming word, so the RAM write
  // is suppressed as well as the pointer advance.
  assign wr_en        = i_rxd_tvalid & ~full & ~i_fifo_invalid;

  // Only committed words are visible to the reader.
  assign avail        = (rd_ptr_q != commit_ptr_q);
  assign rd_en        = i_rd_valid & avail;

  assign o_wr_cnt     = wr_ptr_q - commit_ptr_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    if (i_fifo_invalid) begin
      wr_ptr_d = commit_ptr_q;
    end else if (wr_en) begin
      wr_ptr_d = wr_ptr_inc;
      if (i_rx_tlast) begin
        commit_ptr_d = wr_ptr_inc;
      end
    end

    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_rx_data;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word is presented directly; zero when nothing committed is waiting.
  assign o_data = avail ? mem_q[rd_ptr_q] : '0;
`else
  logic [DW-1:0] rd_data_q, rd_data_d;

  // Output register holds its last value between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign o_data = rd_data_q;
`endif

endmodule

// File: tb/tb_fifo.sv
module tb_fifo;

  localparam int W   = 32;
  localparam int AW  = 9;
  localparam int CAP = 511;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tvalid, rdv, tlast, inv;
  logic [W-1:0]  din;
  logic [W-1:0]  o_data;
  logic [AW-1:0] o_wr_cnt;
  logic          o_rxd_tready;

  fifo #(.C_s_axis_rxd_TDATA_WIDTH(W), .fifo_depth(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_rxd_tvalid   (tvalid),
    .i_rd_valid     (rdv),
    .i_rx_tlast     (tlast),
    .i_fifo_invalid (inv),
    .i_rx_data      (din),
    .o_data         (o_data),
    .o_wr_cnt       (o_wr_cnt),
    .o_rxd_tready   (o_rxd_tready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: committed words (readable) and the pending frame.
  logic [W-1:0] cq[$];
  logic [W-1:0] pq[$];
  logic [W-1:0] m_data = '0;
  int           occ;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data();
`ifdef FIFO_FWFT_EN
    return (cq.size() != 0) ? cq[0] : '0;
`else
    return m_data;
`endif
  endfunction

  // Value o_data must show when no read can happen, given the last word read.
  function automatic logic [W-1:0] hold(input logic [W-1:0] last);
    logic [W-1:0] r;
    r = last;
`ifdef FIFO_FWFT_EN
    r = '0;
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cq.delete();
      pq.delete();
      m_data = '0;
    end else begin
      occ = cq.size() + pq.size();
      if (rdv && cq.size() != 0) m_data = cq.pop_front();
      if (inv) begin
        pq.delete();
      end else if (tvalid && occ < CAP) begin
        pq.push_back(din);
        if (tlast) begin
          while (pq.size() != 0) cq.push_back(pq.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("o_data", o_data, exp_data());
    chk("o_wr_cnt", W'(o_wr_cnt), W'(pq.size()));
    chk("o_rxd_tready", W'(o_rxd_tready), W'((cq.size() + pq.size()) < CAP));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = 1'b0; rdv = 1'b0; tlast = 1'b0; inv = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] d, input logic l);
    tvalid = 1'b1; din = d; tlast = l;
    cyc();
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Pop one word and check it appears with the mode's latency.
  task automatic rd_expect(input string name, input logic [W-1:0] exp);
    rdv = 1'b1;
`ifdef FIFO_FWFT_EN
    chk(name, o_data, exp);
    cyc();
`else
    cyc();
    chk(name, o_data, exp);
`endif
    rdv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int  k;
    logic acc;
    idle();
    din = '0;
    #1;
    chk("rst_data", o_data, 0);
    chk("rst_cnt", W'(o_wr_cnt), 0);
    chk("rst_rdy", W'(o_rxd_tready), 1);
    cyc(); cyc();
    rst = 1'b0;

    // 16-word frame, no reads while storing
    for (int i = 1; i <= 16; i++) begin
      tvalid = 1'b1; din = W'(i); tlast = (i == 16);
      cyc();
      if (i < 16) chk("cnt16", W'(o_wr_cnt), W'(i));
      else        chk("cnt16_commit", W'(o_wr_cnt), 0);
    end
    idle();
    for (int i = 1; i <= 16; i++) rd_expect("rd16", W'(i));
    cyc();

    // Store-and-forward: uncommitted words are invisible to the reader
    for (int i = 1; i <= 5; i++) wr(W'(32'h100 + i), 1'b0);
    rdv = 1'b1;
    cyc(); cyc();
    rdv = 1'b0;
    chk("sf_hold", o_data, hold(32'h10));
    chk("sf_cnt", W'(o_wr_cnt), 5);
    wr(32'h106, 1'b1);
    chk("sf_commit_cnt", W'(o_wr_cnt), 0);
    for (int i = 1; i <= 6; i++) rd_expect("sf_rd", W'(32'h100 + i));

    // Drop: frame A committed, frame B dropped along with a same-cycle word
    for (int i = 1; i <= 3; i++) wr(W'(32'hA0 + i), i == 3);
    for (int i = 1; i <= 4; i++) wr(W'(32'hB0 + i), 1'b0);
    chk("drop_pre_cnt", W'(o_wr_cnt), 4);
    tvalid = 1'b1; din = 32'hB5; tlast = 1'b1; inv = 1'b1;
    cyc();
    idle();
    chk("drop_cnt", W'(o_wr_cnt), 0);
    for (int i = 1; i <= 3; i++) rd_expect("drop_rd", W'(32'hA0 + i));
    rdv = 1'b1;
    cyc(); cyc();
    rdv = 1'b0;
    chk("drop_stall", o_data, hold(32'hA3));
    wr(32'hC1, 1'b1);
    chk("single_cnt", W'(o_wr_cnt), 0);
    rd_expect("single_rd", 32'hC1);

    // Full at 511 words
    for (int i = 0; i < CAP; i++) begin
      tvalid = 1'b1; din = W'(32'h1000 + i); tlast = (i == CAP - 1);
      cyc();
    end
    idle();
    chk("full_rdy", W'(o_rxd_tready), 0);
    chk("full_cnt", W'(o_wr_cnt), 0);
    wr(32'hDEAD, 1'b1);
    chk("full_refuse_rdy", W'(o_rxd_tready), 0);
    rdv = 1'b1;
    cyc();
    rdv = 1'b0;
    chk("free_rdy", W'(o_rxd_tready), 1);
    rdv = 1'b1;
    repeat (515) cyc();
    rdv = 1'b0;
    chk("drain_last", o_data, hold(32'h1000 + CAP - 1));

    // Oversize uncommitted frame stalls until dropped
    for (int i = 0; i < CAP; i++) begin
      tvalid = 1'b1; din = W'(32'h4000 + i); tlast = 1'b0;
      cyc();
    end
    idle();
    chk("ovs_rdy", W'(o_rxd_tready), 0);
    chk("ovs_cnt", W'(o_wr_cnt), CAP);
    rdv = 1'b1;
    repeat (3) cyc();
    rdv = 1'b0;
    chk("ovs_hold_rdy", W'(o_rxd_tready), 0);
    inv = 1'b1;
    cyc();
    inv = 1'b0;
    chk("ovs_drop_rdy", W'(o_rxd_tready), 1);
    chk("ovs_drop_cnt", W'(o_wr_cnt), 0);

    // Three 300-word frames with concurrent reads, crossing the pointer wrap
    k = 0;
    rdv = 1'b1;
    for (int c = 0; c < 3000 && k < 900; c++) begin
      tvalid = 1'b1; din = W'(32'h20000 + k); tlast = ((k % 300) == 299);
      acc = o_rxd_tready;
      cyc();
      if (acc) k++;
    end
    tvalid = 1'b0; tlast = 1'b0;
    chk("wrap_words", W'(k), 900);
    repeat (400) cyc();
    rdv = 1'b0;
    chk("wrap_last", o_data, hold(32'h20000 + 899));
    chk("wrap_cnt", W'(o_wr_cnt), 0);

    // Asynchronous reset mid-frame, observed before any clock edge
    wr(32'h51, 1'b0);
    wr(32'h52, 1'b1);
    wr(32'h61, 1'b0);
    wr(32'h62, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", o_data, 0);
    chk("arst_cnt", W'(o_wr_cnt), 0);
    chk("arst_rdy", W'(o_rxd_tready), 1);
    #9 rst = 1'b0;
    cyc();
    rdv = 1'b1;
    cyc();
    rdv = 1'b0;
    chk("arst_empty", o_data, 0);
    wr(32'h71, 1'b1);
    rd_expect("arst_rd", 32'h71);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
